// File: rtl/im_pkg.sv
// Shared definitions for the instruction-memory fetch arbiter.
// Optional macro: IM_ARB_STATS_EN (per-core grant counters).
package im_pkg;

   localparam int unsigned IM_ADDR_W    = 16;
   localparam int unsigned IM_DATA_W    = 16;
   localparam int unsigned IM_ARB_CNT_W = 16;

   // RETURN means a read word is being handed back this cycle
   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_RETURN = 1'b1
   } arb_state_e;

endpackage : im_pkg

// File: rtl/im_fetch_arbiter_if.sv
// Core-fetch / IM bus seen by the arbiter; master = cores + IM, slave = arbiter.
interface im_fetch_arbiter_if #(
   parameter int unsigned NUM_CORES = 4,
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned DATA_W    = 16
);

   logic [NUM_CORES-1:0]        core_req;
   logic [NUM_CORES*ADDR_W-1:0] core_addr;
   logic [NUM_CORES-1:0]        core_gnt;
   logic [NUM_CORES-1:0]        core_rvalid;
   logic [DATA_W-1:0]           core_rdata;
   logic                        arb_stall;
   logic [ADDR_W-1:0]           im_addr;
   logic [DATA_W-1:0]           im_data;

   modport master (
      output core_req, core_addr, arb_stall, im_data,
      input  core_gnt, core_rvalid, core_rdata, im_addr
   );

   modport slave (
      input  core_req, core_addr, arb_stall, im_data,
      output core_gnt, core_rvalid, core_rdata, im_addr
   );

endinterface : im_fetch_arbiter_if

// File: rtl/im_fetch_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping.
module rr_priority_pick #(
   parameter int unsigned N = 4,
   localparam int unsigned ID_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] ptr,
   output logic [N-1:0]    gnt_c,
   output logic [ID_W-1:0] id_c,
   output logic            valid_c
);

   // Scan N positions starting at ptr; the first hit wins
   always_comb begin
      int unsigned idx;
      gnt_c   = '0;
      id_c    = '0;
      valid_c = 1'b0;
      idx     = 0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = (32'(ptr) + k) % N;
         if (!valid_c && req[idx]) begin
            valid_c    = 1'b1;
            gnt_c[idx] = 1'b1;
            id_c       = ID_W'(idx);
         end
      end
   end

endmodule : rr_priority_pick

// File: rtl/im_fetch_arbiter.sv
// Round-robin arbiter sharing one single-port instruction memory between cores.
// Optional macro: IM_ARB_STATS_EN adds saturating per-core grant counters.
module im_fetch_arbiter
   import im_pkg::*;
#(
   parameter int unsigned NUM_CORES = 4,
   parameter int unsigned ADDR_W    = IM_ADDR_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   im_fetch_arbiter_if.slave     bus
`ifdef IM_ARB_STATS_EN
   ,
   output logic [NUM_CORES*IM_ARB_CNT_W-1:0] grant_count
`endif
);

   localparam int unsigned ID_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   arb_state_e           state_q, state_d;
   logic [ID_W-1:0]      rr_ptr, ptr_d;
   logic [ID_W-1:0]      rid_q, rid_d;
   logic [NUM_CORES-1:0] pick_req;
   logic [NUM_CORES-1:0] pick_gnt;
   logic [ID_W-1:0]      pick_id;
   logic                 pick_valid;

   // Stall masks all requests so neither a grant nor a pointer move happens
   assign pick_req = bus.arb_stall ? '0 : bus.core_req;

   rr_priority_pick #(.N(NUM_CORES)) u_pick (
      .req     (pick_req),
      .ptr     (rr_ptr),
      .gnt_c   (pick_gnt),
      .id_c    (pick_id),
      .valid_c (pick_valid)
   );

   // State register: return-phase flag, returning core id, rotation pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ARB_IDLE;
         rid_q   <= '0;
         rr_ptr  <= '0;
      end else begin
         state_q <= state_d;
         rid_q   <= rid_d;
         rr_ptr  <= ptr_d;
      end
   end

   // Next state: any grant now means a word returns next cycle
   always_comb begin
      state_d = ARB_IDLE;
      rid_d   = rid_q;
      ptr_d   = rr_ptr;
      if (pick_valid) begin
         state_d = ARB_RETURN;
         rid_d   = pick_id;
         ptr_d   = (pick_id == ID_W'(NUM_CORES - 1)) ? '0 : pick_id + ID_W'(1);
      end
   end

   // Outputs: grant and IM address follow the pick, rvalid follows the state
   always_comb begin
      bus.core_gnt    = pick_gnt;
      bus.im_addr     = '0;
      bus.core_rvalid = '0;
      bus.core_rdata  = bus.im_data;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
         if (pick_gnt[i]) begin
            bus.im_addr = bus.core_addr[i*ADDR_W +: ADDR_W];
         end
      end
      if (state_q == ARB_RETURN) begin
         bus.core_rvalid[rid_q] = 1'b1;
      end
   end

`ifdef IM_ARB_STATS_EN
   logic [NUM_CORES-1:0][IM_ARB_CNT_W-1:0] cnt_q;

   // Per-core grant counters that stick at all-ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (pick_gnt[i] && (cnt_q[i] != '1)) begin
               cnt_q[i] <= cnt_q[i] + IM_ARB_CNT_W'(1);
            end
         end
      end
   end

   assign grant_count = cnt_q;
`endif

endmodule : im_fetch_arbiter

// File: tb/tb_im_fetch_arbiter.sv
// Directed bench for im_fetch_arbiter with a 1-cycle registered IM model.
module tb_im_fetch_arbiter;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   im_fetch_arbiter_if #(.NUM_CORES(4), .ADDR_W(16), .DATA_W(16)) bus ();

`ifdef IM_ARB_STATS_EN
   logic [63:0] grant_count;
`endif

   im_fetch_arbiter #(.NUM_CORES(4), .ADDR_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef IM_ARB_STATS_EN
      ,
      .grant_count (grant_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h5AA5;
   endfunction

   // IM model: registered read
   always @(posedge clk) bus.im_data <= mem_word(bus.im_addr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_addr(input int i, input logic [15:0] a);
      bus.core_addr[i*16 +: 16] = a;
   endtask

   task automatic chk_cycle(input string tag, input logic [3:0] gnt, input logic [15:0] addr,
                            input logic [3:0] rv, input logic rd_chk, input logic [15:0] rd);
      @(negedge clk);
      chk({tag, ".gnt"}, 32'(bus.core_gnt), 32'(gnt));
      chk({tag, ".im_addr"}, 32'(bus.im_addr), 32'(addr));
      chk({tag, ".rvalid"}, 32'(bus.core_rvalid), 32'(rv));
      if (rd_chk) chk({tag, ".rdata"}, 32'(bus.core_rdata), 32'(rd));
   endtask

   initial begin
      logic [15:0] a_now, a_prev;
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus.core_req  = '0;
      bus.core_addr = '0;
      bus.arb_stall = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst.gnt", 32'(bus.core_gnt), 32'h0);
      chk("rst.rvalid", 32'(bus.core_rvalid), 32'h0);
      chk("rst.im_addr", 32'(bus.im_addr), 32'h0);

      // reset release, idle
      tick(); rst_n = 1'b1;
      chk_cycle("idle", 4'b0000, 16'h0, 4'b0000, 1'b0, 16'h0);

      // all cores requesting: strict rotation 0,1,2,3,0,1,2,3
      a_prev = '0;
      for (int k = 0; k <= 8; k++) begin
         tick();
         bus.core_req = (k < 8) ? 4'b1111 : 4'b0000;
         for (int i = 0; i < 4; i++) set_addr(i, 16'((k < 4) ? 16 + i : 32 + i));
         a_now = 16'((k < 4) ? 16 + (k % 4) : 32 + (k % 4));
         chk_cycle($sformatf("rot%0d", k),
                   (k < 8) ? 4'(1 << (k % 4)) : 4'b0000,
                   (k < 8) ? a_now : 16'h0,
                   (k > 0) ? 4'(1 << ((k - 1) % 4)) : 4'b0000,
                   k > 0, mem_word(a_prev));
         a_prev = a_now;
      end

      // single requester core 1 granted every cycle, wide address passes through
      tick(); bus.core_req = 4'b0010; set_addr(1, 16'd5);
      chk_cycle("one0", 4'b0010, 16'd5, 4'b0000, 1'b0, 16'h0);
      tick(); set_addr(1, 16'hBEEF);
      chk_cycle("one1", 4'b0010, 16'hBEEF, 4'b0010, 1'b1, mem_word(16'd5));
      tick(); set_addr(1, 16'h0400);
      chk_cycle("one2", 4'b0010, 16'h0400, 4'b0010, 1'b1, mem_word(16'hBEEF));
      tick(); bus.core_req = 4'b0000;
      chk_cycle("one3", 4'b0000, 16'h0, 4'b0010, 1'b1, mem_word(16'h0400));

      // pointer 2 -> grant core 2, then pointer 3 with req 1001 -> 3 then wrap to 0
      tick(); bus.core_req = 4'b0100; set_addr(2, 16'd7);
      chk_cycle("wrap0", 4'b0100, 16'd7, 4'b0000, 1'b0, 16'h0);
      tick(); bus.core_req = 4'b1001; set_addr(0, 16'd20); set_addr(3, 16'd23);
      chk_cycle("wrap1", 4'b1000, 16'd23, 4'b0100, 1'b1, mem_word(16'd7));
      tick(); bus.core_req = 4'b0001;
      chk_cycle("wrap2", 4'b0001, 16'd20, 4'b1000, 1'b1, mem_word(16'd23));
      tick(); bus.core_req = 4'b0000;
      chk_cycle("wrap3", 4'b0000, 16'h0, 4'b0001, 1'b1, mem_word(16'd20));

      // stall right after a grant: return still completes, pointer held
      tick(); bus.core_req = 4'b0011; set_addr(0, 16'd40); set_addr(1, 16'd41);
      chk_cycle("stl0", 4'b0010, 16'd41, 4'b0000, 1'b0, 16'h0);
      tick(); bus.core_req = 4'b0001; bus.arb_stall = 1'b1;
      chk_cycle("stl1", 4'b0000, 16'h0, 4'b0010, 1'b1, mem_word(16'd41));
      tick();
      chk_cycle("stl2", 4'b0000, 16'h0, 4'b0000, 1'b0, 16'h0);
      tick(); bus.arb_stall = 1'b0; bus.core_req = 4'b1001; set_addr(3, 16'd43);
      chk_cycle("stl3", 4'b1000, 16'd43, 4'b0000, 1'b0, 16'h0);
      tick(); bus.core_req = 4'b0001;
      chk_cycle("stl4", 4'b0001, 16'd40, 4'b1000, 1'b1, mem_word(16'd43));
      tick(); bus.core_req = 4'b0000;
      chk_cycle("stl5", 4'b0000, 16'h0, 4'b0001, 1'b1, mem_word(16'd40));

      // reset in the cycle after a grant discards the pending return
      tick(); bus.core_req = 4'b0100; set_addr(2, 16'd50);
      chk_cycle("mrst0", 4'b0100, 16'd50, 4'b0000, 1'b0, 16'h0);
      tick(); rst_n = 1'b0; bus.core_req = 4'b0000;
      chk_cycle("mrst1", 4'b0000, 16'h0, 4'b0000, 1'b0, 16'h0);
      tick(); rst_n = 1'b1; bus.core_req = 4'b1001;
      set_addr(0, 16'd60); set_addr(3, 16'd63);
      chk_cycle("mrst2", 4'b0001, 16'd60, 4'b0000, 1'b0, 16'h0);
      tick(); bus.core_req = 4'b0000;
      chk_cycle("mrst3", 4'b0000, 16'h0, 4'b0001, 1'b1, mem_word(16'd60));

`ifdef IM_ARB_STATS_EN
      // saturation of core 0 counter
      tick(); bus.core_req = 4'b0001; set_addr(0, 16'd1);
      repeat (70000) @(posedge clk);
      #1; bus.core_req = 4'b0000;
      @(negedge clk);
      chk("stats.sat0", 32'(grant_count[15:0]), 32'hFFFF);
      chk("stats.core1", 32'(grant_count[31:16]), 32'h0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_im_fetch_arbiter
